// File: rtl/div_scheduler_if.sv
// div_scheduler_if: configuration, control and status signals of the divider scheduler.
interface div_scheduler_if #(parameter int WIDTH = 17);
   logic [WIDTH-1:0] cfg_div;
   logic             cfg_load;
   logic             cfg_ack;
   logic             cfg_err;
   logic             start;
   logic             stop;
   logic [7:0]       burst_len;
   logic             busy;
   logic             tick;
   logic             s_clk;
   logic             done;
   modport master (
      output cfg_div, cfg_load, start, stop, burst_len,
      input  cfg_ack, cfg_err, busy, tick, s_clk, done
   );
   modport slave (
      input  cfg_div, cfg_load, start, stop, burst_len,
      output cfg_ack, cfg_err, busy, tick, s_clk, done
   );
endinterface

// File: rtl/div_scheduler.sv
// div_scheduler: programmable clock divider with continuous/burst tick generation.
module div_scheduler #(
   parameter int WIDTH       = 17,
   parameter int DEFAULT_DIV = 100000
) (
   input logic           clk,
   input logic           reset,
   div_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, BURST, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_cnt, r_div, r_shadow, w_cnt;
   logic [7:0]       r_rem, w_rem;
   logic             r_pend, r_tick, r_sclk, r_busy, r_done, r_ack, r_err;
   logic             w_active, w_wrap, w_cfg_ok, w_accept;
   logic             w_tick, w_sclk, w_busy, w_done;
   assign w_active = (r_state == RUN) || (r_state == BURST);
   assign w_wrap   = w_active && !bus.stop && (r_cnt == r_div - WIDTH'(1));
   assign w_cfg_ok = bus.cfg_div >= WIDTH'(2);
   assign w_accept = (r_state == IDLE) && bus.start && !bus.stop;
   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE)
         w_next = w_accept ? ((bus.burst_len == 8'd0) ? RUN : BURST) : IDLE;
      else if (r_state == DONE || bus.stop)
         w_next = IDLE;
      else if (r_state == BURST && w_wrap && r_rem == 8'd1)
         w_next = DONE;
   end
   always_comb begin
      w_tick = w_wrap;
      w_busy = (w_next == RUN) || (w_next == BURST);
      w_sclk = (w_next == IDLE) ? 1'b0 : r_sclk ^ w_wrap;
      w_done = (r_state == DONE);
      w_cnt  = (w_active && !bus.stop && !w_wrap) ? r_cnt + WIDTH'(1) : '0;
      w_rem  = w_accept ? bus.burst_len : (r_state == BURST && w_wrap) ? r_rem - 8'd1 : r_rem;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_div    <= WIDTH'(DEFAULT_DIV);
         r_shadow <= WIDTH'(DEFAULT_DIV);
         r_pend   <= 1'b0;
         r_tick   <= 1'b0;
         r_sclk   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_cnt  <= w_cnt;
         r_rem  <= w_rem;
         r_tick <= w_tick;
         r_sclk <= w_sclk;
         r_busy <= w_busy;
         r_done <= w_done;
         r_ack  <= bus.cfg_load && w_cfg_ok;
         r_err  <= bus.cfg_load && !w_cfg_ok;
         // While running, a new divisor waits in the shadow until the current period ends.
         if (bus.cfg_load && w_cfg_ok && !w_active) begin
            r_div    <= bus.cfg_div;
            r_shadow <= bus.cfg_div;
            r_pend   <= 1'b0;
         end else if (bus.cfg_load && w_cfg_ok) begin
            r_shadow <= bus.cfg_div;
            r_pend   <= 1'b1;
            if (r_pend && w_wrap) r_div <= r_shadow;
         end else if (r_pend && (w_wrap || !w_active)) begin
            r_div  <= r_shadow;
            r_pend <= 1'b0;
         end
      end
   end
   assign bus.tick    = r_tick;
   assign bus.s_clk   = r_sclk;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.cfg_ack = r_ack;
   assign bus.cfg_err = r_err;
endmodule
